// File: rtl/mips_bp_pkg.sv
// Shared constants and helpers for the bimodal branch predictor.
// Contents: MIPS branch opcodes, REGIMM rt codes, 2-bit counter encodings, saturating update.
package mips_bp_pkg;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && (cnt != ST)) begin
      nxt = cnt + 2'd1;
    end else if (!taken && (cnt != SNT)) begin
      nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bimodal_predictor_if.sv
// Signal bundle between the core pipeline (master) and the bimodal predictor (slave).
interface bimodal_predictor_if;
  logic        STALL;
  logic        FLUSH;
  logic [31:0] Instr_input;
  logic [31:0] Instr_addr_input;
  logic        Branch_resolved;
  logic [31:0] Branch_resolved_addr;
  logic        Branch_outcome;
  logic        Branch_mispredicted;
  logic        Taken;
  logic        Is_branch;
  logic [31:0] Predict_count;
  logic [31:0] Mispredict_count;

  modport master (
    output STALL, FLUSH, Instr_input, Instr_addr_input,
    output Branch_resolved, Branch_resolved_addr, Branch_outcome, Branch_mispredicted,
    input  Taken, Is_branch, Predict_count, Mispredict_count
  );

  modport slave (
    input  STALL, FLUSH, Instr_input, Instr_addr_input,
    input  Branch_resolved, Branch_resolved_addr, Branch_outcome, Branch_mispredicted,
    output Taken, Is_branch, Predict_count, Mispredict_count
  );
endinterface

// File: rtl/bp_counter_table.sv
// Table of 2-bit saturating counters: one combinational read port, one training write port,
// with write-first bypass so a same-cycle read sees the trained value.
module bp_counter_table
  import mips_bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter logic [1:0]  CNT_INIT   = 2'b01
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [1:0]            rd_cnt,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_taken
);

  localparam int unsigned Entries = 2 ** INDEX_BITS;

  logic [1:0] cnt_q [Entries];
  logic [1:0] wr_cnt;

  assign wr_cnt = sat_update(cnt_q[wr_idx], wr_taken);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        cnt_q[i] <= CNT_INIT;
      end
    end else if (wr_en) begin
      cnt_q[wr_idx] <= wr_cnt;
    end
  end

  always_comb begin
    rd_cnt = cnt_q[rd_idx];
    if (wr_en && (wr_idx == rd_idx)) begin
      rd_cnt = wr_cnt;
    end
  end

endmodule

// File: rtl/bimodal_predictor.sv
// Bimodal branch predictor: decodes the IF instruction, registers a taken/branch prediction
// for MEM, trains the counter table from MEM resolutions and keeps prediction statistics.
module bimodal_predictor
  import mips_bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter logic [1:0]  CNT_INIT   = 2'b01
) (
  input logic                CLK,
  input logic                RESET,
  bimodal_predictor_if.slave bus
);

  logic [5:0]            opcode;
  logic [4:0]            rt;
  logic                  is_br;
  logic [1:0]            rd_cnt;
  logic [INDEX_BITS-1:0] rd_idx;
  logic [INDEX_BITS-1:0] wr_idx;
  logic                  taken_q;
  logic                  is_branch_q;
  logic [31:0]           pred_cnt_q;
  logic [31:0]           mis_cnt_q;

  assign opcode = bus.Instr_input[31:26];
  assign rt     = bus.Instr_input[20:16];
  assign rd_idx = bus.Instr_addr_input[INDEX_BITS+1:2];
  assign wr_idx = bus.Branch_resolved_addr[INDEX_BITS+1:2];

  always_comb begin
    is_br = 1'b0;
    case (opcode)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_br = 1'b1;
      OP_REGIMM:                        is_br = (rt == RT_BLTZ) || (rt == RT_BGEZ);
      default:                          is_br = 1'b0;
    endcase
  end

  bp_counter_table #(
    .INDEX_BITS(INDEX_BITS),
    .CNT_INIT  (CNT_INIT)
  ) u_table (
    .CLK     (CLK),
    .RESET   (RESET),
    .rd_idx  (rd_idx),
    .rd_cnt  (rd_cnt),
    .wr_en   (bus.Branch_resolved),
    .wr_idx  (wr_idx),
    .wr_taken(bus.Branch_outcome)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      taken_q     <= 1'b0;
      is_branch_q <= 1'b0;
      pred_cnt_q  <= '0;
    end else if (bus.FLUSH) begin
      taken_q     <= 1'b0;
      is_branch_q <= 1'b0;
    end else if (!bus.STALL) begin
      taken_q     <= rd_cnt[1] & is_br;
      is_branch_q <= is_br;
      if (is_br) begin
        pred_cnt_q <= pred_cnt_q + 32'd1;
      end
    end
  end

  // Training statistics run independently of STALL/FLUSH.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mis_cnt_q <= '0;
    end else if (bus.Branch_resolved && bus.Branch_mispredicted) begin
      mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign bus.Taken            = taken_q;
  assign bus.Is_branch        = is_branch_q;
  assign bus.Predict_count    = pred_cnt_q;
  assign bus.Mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_bimodal_predictor.sv
// Self-checking bench: directed and random steps checked against a behavioural model
// of the predictor table, outputs and statistics.
module tb_bimodal_predictor;

  localparam int unsigned IndexBits = 6;
  localparam int unsigned Entries   = 2 ** IndexBits;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  int          m_tab [Entries];
  logic        m_taken;
  logic        m_isbr;
  logic [31:0] m_pred;
  logic [31:0] m_mis;

  bimodal_predictor_if bus ();

  bimodal_predictor #(
    .INDEX_BITS(IndexBits),
    .CNT_INIT  (2'b01)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_is_branch(input logic [31:0] instr);
    int op;
    int rtv;
    op  = int'(instr[31:26]);
    rtv = int'(instr[20:16]);
    if (op >= 4 && op <= 7) return 1'b1;
    if (op == 1) return rtv <= 1;
    return 1'b0;
  endfunction

  function automatic int idx_of(input logic [31:0] addr);
    return int'((addr >> 2) % Entries);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < Entries; i++) m_tab[i] = 1;
    m_taken = 1'b0;
    m_isbr  = 1'b0;
    m_pred  = '0;
    m_mis   = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".Taken"}, {31'd0, bus.Taken}, {31'd0, m_taken});
    check({tag, ".Is_branch"}, {31'd0, bus.Is_branch}, {31'd0, m_isbr});
    check({tag, ".Predict_count"}, bus.Predict_count, m_pred);
    check({tag, ".Mispredict_count"}, bus.Mispredict_count, m_mis);
  endtask

  // One clock: drive inputs, advance, apply the spec rules to the model, compare.
  task automatic step(input string tag, input logic stall, input logic flush,
                      input logic [31:0] instr, input logic [31:0] addr,
                      input logic res, input logic [31:0] raddr,
                      input logic outc, input logic mis);
    logic br;
    int   r;
    bus.STALL                = stall;
    bus.FLUSH                = flush;
    bus.Instr_input          = instr;
    bus.Instr_addr_input     = addr;
    bus.Branch_resolved      = res;
    bus.Branch_resolved_addr = raddr;
    bus.Branch_outcome       = outc;
    bus.Branch_mispredicted  = mis;
    @(posedge CLK);
    if (res) begin
      r = idx_of(raddr);
      m_tab[r] = outc ? ((m_tab[r] == 3) ? 3 : m_tab[r] + 1)
                      : ((m_tab[r] == 0) ? 0 : m_tab[r] - 1);
      if (mis) m_mis = m_mis + 32'd1;
    end
    br = model_is_branch(instr);
    if (flush) begin
      m_taken = 1'b0;
      m_isbr  = 1'b0;
    end else if (!stall) begin
      m_isbr  = br;
      m_taken = br && (m_tab[idx_of(addr)] >= 2);
      if (br) m_pred = m_pred + 32'd1;
    end
    #1;
    check_all(tag);
  endtask

  localparam logic [31:0] Beq  = 32'h1000_0003;
  localparam logic [31:0] Bne  = 32'h1420_fffe;
  localparam logic [31:0] Addu = 32'h0000_0021;
  localparam logic [31:0] Jmp  = 32'h0810_0004;
  localparam logic [31:0] Nop  = 32'h0000_0000;
  localparam logic [31:0] Pc0  = 32'h0040_0010;

  initial begin
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] raddr;
    bus.STALL = 0; bus.FLUSH = 0; bus.Instr_input = 0; bus.Instr_addr_input = 0;
    bus.Branch_resolved = 0; bus.Branch_resolved_addr = 0;
    bus.Branch_outcome = 0; bus.Branch_mispredicted = 0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge CLK);
    #1 RESET = 1'b1;

    step("beq_first", 0, 0, Beq, Pc0, 0, 0, 0, 0);
    step("train1", 0, 0, Nop, Pc0, 1, Pc0, 1, 0);
    step("train2", 0, 0, Nop, Pc0, 1, Pc0, 1, 0);
    step("beq_taken", 0, 0, Beq, Pc0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("train_sat", 0, 0, Nop, Pc0, 1, Pc0, 1, 0);
    step("train_nt", 0, 0, Nop, Pc0, 1, Pc0, 0, 0);
    step("beq_wt", 0, 0, Beq, Pc0, 0, 0, 0, 0);
    step("addu", 0, 0, Addu, Pc0, 0, 0, 0, 0);
    step("jump", 0, 0, Jmp, Pc0, 0, 0, 0, 0);

    step("pre_stall", 0, 0, Beq, Pc0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("stall_hold", 1, 0, Addu, 32'h0040_0020, 0, 0, 0, 0);
    step("stall_flush", 1, 1, Beq, Pc0, 0, 0, 0, 0);

    step("bypass", 0, 0, Bne, 32'h0040_0040, 1, 32'h0040_0040, 1, 0);
    step("alias", 0, 0, Bne, 32'h0040_0044, 1, 32'h0040_0144, 1, 0);
    step("alias_rd", 0, 0, Beq, 32'h0040_0144, 0, 0, 0, 0);

    step("mis1", 0, 0, Nop, Pc0, 1, 32'h0040_0080, 0, 1);
    step("mis2", 0, 0, Nop, Pc0, 1, 32'h0040_0084, 1, 1);
    step("mis_norres", 0, 0, Nop, Pc0, 0, 32'h0040_0088, 1, 1);
    step("mis3", 0, 0, Nop, Pc0, 1, 32'h0040_008c, 0, 1);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2, 3: instr = {6'($urandom_range(4, 7)), 26'($urandom)};
        4:          instr = {6'b000001, 5'($urandom), 5'($urandom_range(0, 3)), 16'($urandom)};
        default:    instr = $urandom;
      endcase
      addr  = 32'h0040_0000 | (32'($urandom_range(0, 511)) << 2);
      raddr = 32'h0040_0000 | (32'($urandom_range(0, 511)) << 2);
      step("random", ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0), instr, addr,
           1'($urandom), raddr, 1'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 3; i++) step("pre_rst_train", 0, 0, Nop, Pc0, 1, Pc0, 1, 0);
    step("pre_rst_look", 0, 0, Beq, Pc0, 1, Pc0, 1, 1);
    // Strobe held across the asserted reset must be dropped.
    bus.Branch_resolved = 1; bus.Branch_resolved_addr = Pc0;
    bus.Branch_outcome = 1; bus.Branch_mispredicted = 1;
    RESET = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge CLK);
    #1;
    check_all("reset_hold");
    RESET = 1'b1;
    step("post_reset", 0, 0, Beq, Pc0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
